// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and the execution unit.
package instr_register_pkg;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;
    typedef logic signed [63:0] result_t;

    typedef enum logic [3:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    // Execution unit sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        OUT,
        DONE
    } exec_state_t;

    // Opcodes that occupy the long (multi-cycle) execution slot.
    function automatic logic is_long_op(input opcode_t opc);
        return (opc == MULT) || (opc == DIV) || (opc == MOD);
    endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational opcode-to-result datapath; operands are sign-extended to 64 bits.
module instr_alu
    import instr_register_pkg::*;
(
    input  opcode_t  opc,
    input  operand_t op_a,
    input  operand_t op_b,
    output result_t  result,
    output logic     div_err
);

    result_t a_ext;
    result_t b_ext;

    assign a_ext = {{32{op_a[31]}}, op_a};
    assign b_ext = {{32{op_b[31]}}, op_b};

    // Select the result for the current opcode; a zero divisor yields 0 and raises div_err.
    always_comb begin
        result  = '0;
        div_err = 1'b0;
        case (opc)
            ZERO:  result = '0;
            PASSA: result = a_ext;
            PASSB: result = b_ext;
            ADD:   result = a_ext + b_ext;
            SUB:   result = a_ext - b_ext;
            MULT:  result = a_ext * b_ext;
            DIV: begin
                if (b_ext == '0) div_err = 1'b1;
                else             result  = a_ext / b_ext;
            end
            MOD: begin
                if (b_ext == '0) div_err = 1'b1;
                else             result  = a_ext % b_ext;
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_exec_unit.sv
// Walks a block of instruction-register entries, executes each one and
// presents the results on a valid/ready output port.
//
// Output handshake: res_valid rises when a result is ready and stays high,
// with res_data/res_addr/res_opc/div_err held constant, until the cycle in
// which res_ready is also high; that edge transfers the result. res_ready
// is ignored while res_valid is low.
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int unsigned LONG_LAT = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  address_t     first_addr,
    input  logic [5:0]   count,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         res_valid,
    input  logic         res_ready,
    output result_t      res_data,
    output address_t     res_addr,
    output opcode_t      res_opc,
    output logic         div_err,
    output logic         busy,
    output logic         done
);

    // Latency counter reload value: EXEC lasts reload+1 cycles.
    localparam logic [3:0] LAT_LOAD = 4'(LONG_LAT - 1);

    exec_state_t  state;
    address_t     ptr;
    logic [5:0]   remaining;
    logic [3:0]   lat_cnt;
    instruction_t instr_q;

    result_t      alu_result;
    logic         alu_div_err;

    instr_alu u_alu (
        .opc     (instr_q.opc),
        .op_a    (instr_q.op_a),
        .op_b    (instr_q.op_b),
        .result  (alu_result),
        .div_err (alu_div_err)
    );

    // Job sequencer; every output is registered and changes only on a state transition.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            ptr          <= '0;
            remaining    <= '0;
            lat_cnt      <= '0;
            instr_q      <= '0;
            read_pointer <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_addr     <= '0;
            res_opc      <= ZERO;
            div_err      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr       <= first_addr;
                        remaining <= count;
                        busy      <= 1'b1;
                        if (count != 6'd0) begin
                            // read_pointer is set on entry so it equals ptr throughout FETCH.
                            read_pointer <= first_addr;
                            state        <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                FETCH: begin
                    instr_q <= instruction_word;
                    lat_cnt <= is_long_op(instruction_word.opc) ? LAT_LOAD : 4'd0;
                    state   <= EXEC;
                end

                EXEC: begin
                    if (lat_cnt == 4'd0) begin
                        res_data  <= alu_result;
                        div_err   <= alu_div_err;
                        res_opc   <= instr_q.opc;
                        res_addr  <= ptr;
                        res_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end

                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        ptr       <= ptr + 5'd1;
                        remaining <= remaining - 6'd1;
                        if (remaining > 6'd1) begin
                            read_pointer <= ptr + 5'd1;
                            state        <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    res_valid <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
